// File: rtl/arcabuco_execution.sv
// Execute stage: operand forwarding muxes, combinational ALU, and a
// multiply/divide unit (single-cycle multiply, 1-bit/cycle restoring divider).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | unit free; a muldiv_en request is captured here
// ST_DIV  | divider iterating, one quotient bit per cycle (busy=1)
module arcabuco_execution (
  input  logic        clock,
  input  logic        rst,
  input  logic [4:0]  alu_selector,
  input  logic [2:0]  muldiv_selector,
  input  logic        muldiv_en,
  input  logic [1:0]  mux1_select,
  input  logic [1:0]  mux2_select,
  input  logic        mux3_select,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] imm,
  input  logic [31:0] fw1,
  input  logic [31:0] fw2,
  output logic [31:0] alu_result,
  output logic        comp_res,
  output logic        arith_ovf,
  output logic [31:0] store_data,
  output logic [31:0] muldiv_result,
  output logic        muldiv_busy,
  output logic        muldiv_done
);

  localparam logic [4:0] ALU_ADD = 5'd0,  ALU_SUB = 5'd1,  ALU_SLL = 5'd2,  ALU_SLT = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4, ALU_XOR = 5'd5,  ALU_SRL = 5'd6,  ALU_SRA = 5'd7;
  localparam logic [4:0] ALU_OR = 5'd8,   ALU_AND = 5'd9,  ALU_EQ = 5'd10,  ALU_NE = 5'd11;
  localparam logic [4:0] ALU_LT = 5'd12,  ALU_GE = 5'd13,  ALU_LTU = 5'd14, ALU_GEU = 5'd15;
  localparam logic [4:0] ALU_PASS_B = 5'd16;

  localparam logic [2:0] MD_MUL = 3'd0, MD_MULH = 3'd1, MD_MULHSU = 3'd2;

  typedef enum logic {ST_IDLE, ST_DIV} t_state;

  logic [31:0] op_a, fwd_b, op_b;
  logic [31:0] sum, diff;
  logic        lt_s, lt_u;
  logic [31:0] alu_res;
  logic        cmp, ovf;

  // Operand selection; store data is taken before the immediate mux
  always_comb begin
    case (mux1_select)
      2'd0:    op_a = rs1;
      2'd1:    op_a = fw1;
      2'd2:    op_a = fw2;
      default: op_a = 32'd0;
    endcase
    case (mux2_select)
      2'd0:    fwd_b = rs2;
      2'd1:    fwd_b = fw1;
      2'd2:    fwd_b = fw2;
      default: fwd_b = 32'd0;
    endcase
    op_b = mux3_select ? imm : fwd_b;
  end

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;
  assign lt_s = $signed(op_a) < $signed(op_b);
  assign lt_u = op_a < op_b;

  // ALU result, compare flag and signed overflow
  always_comb begin
    alu_res = 32'd0;
    cmp     = 1'b0;
    ovf     = 1'b0;
    case (alu_selector)
      ALU_ADD: begin
        alu_res = sum;
        ovf     = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
      end
      ALU_SUB: begin
        alu_res = diff;
        ovf     = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
      end
      ALU_SLL:    alu_res = op_a << op_b[4:0];
      ALU_SRL:    alu_res = op_a >> op_b[4:0];
      ALU_SRA:    alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
      ALU_XOR:    alu_res = op_a ^ op_b;
      ALU_OR:     alu_res = op_a | op_b;
      ALU_AND:    alu_res = op_a & op_b;
      ALU_SLT,
      ALU_LT:     cmp = lt_s;
      ALU_SLTU,
      ALU_LTU:    cmp = lt_u;
      ALU_GE:     cmp = ~lt_s;
      ALU_GEU:    cmp = ~lt_u;
      ALU_EQ:     cmp = (op_a == op_b);
      ALU_NE:     cmp = (op_a != op_b);
      ALU_PASS_B: alu_res = op_b;
      default:    alu_res = 32'd0;
    endcase
    if (cmp) alu_res = 32'd1;
  end

  assign alu_result = alu_res;
  assign comp_res   = cmp;
  assign arith_ovf  = ovf;
  assign store_data = fwd_b;

  // Multiply: sign-extend to 64 bits so one unsigned multiplier covers all variants
  logic        mul_a_signed, mul_b_signed;
  logic [63:0] ext_a, ext_b, product;
  logic [31:0] mul_res;
  logic        in_div_signed;
  logic [31:0] abs_a_in;

  assign mul_a_signed  = (muldiv_selector == MD_MULH) || (muldiv_selector == MD_MULHSU);
  assign mul_b_signed  = (muldiv_selector == MD_MULH);
  assign ext_a         = {{32{mul_a_signed & op_a[31]}}, op_a};
  assign ext_b         = {{32{mul_b_signed & op_b[31]}}, op_b};
  assign product       = ext_a * ext_b;
  assign mul_res       = (muldiv_selector == MD_MUL) ? product[31:0] : product[63:32];
  assign in_div_signed = muldiv_selector[2] & ~muldiv_selector[0];
  assign abs_a_in      = (in_div_signed & op_a[31]) ? -op_a : op_a;

  t_state      state_q, state_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d;

  // Divider datapath: one restoring step per cycle on magnitudes, sign fix at the end
  logic        op_signed_q;
  logic [31:0] divisor;
  logic [32:0] r_shift, r_sub;
  logic        q_bit;
  logic [31:0] rem_step, quo_step, quo_fin, rem_fin, div_res;

  assign op_signed_q = op_q[2] & ~op_q[0];
  assign divisor     = (op_signed_q & b_q[31]) ? -b_q : b_q;
  assign r_shift     = {rem_q, quo_q[31]};
  assign r_sub       = r_shift - {1'b0, divisor};
  assign q_bit       = ~r_sub[32];
  assign rem_step    = q_bit ? r_sub[31:0] : r_shift[31:0];
  assign quo_step    = {quo_q[30:0], q_bit};
  assign quo_fin     = (b_q == 32'd0) ? 32'hFFFF_FFFF :
                       (op_signed_q & (a_q[31] ^ b_q[31])) ? -quo_step : quo_step;
  assign rem_fin     = (b_q == 32'd0) ? a_q :
                       (op_signed_q & a_q[31]) ? -rem_step : rem_step;
  assign div_res     = op_q[1] ? rem_fin : quo_fin;

  // Mul/div state register
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      result_q <= 32'd0;
      cnt_q    <= 5'd0;
      op_q     <= 3'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
    end
  end

  // Capture requests when idle, iterate the divider, pulse done on completion
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    result_d = result_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    case (state_q)
      ST_IDLE: begin
        if (muldiv_en) begin
          op_d = muldiv_selector;
          a_d  = op_a;
          b_d  = op_b;
          if (!muldiv_selector[2]) begin
            result_d = mul_res;
            done_d   = 1'b1;
          end else begin
            state_d = ST_DIV;
            cnt_d   = 5'd31;
            rem_d   = 32'd0;
            quo_d   = abs_a_in;
          end
        end
      end
      ST_DIV: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d  = ST_IDLE;
          result_d = div_res;
          done_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign muldiv_result = result_q;
  assign muldiv_busy   = (state_q == ST_DIV);
  assign muldiv_done   = done_q;

endmodule

// File: tb/tb_arcabuco_execution.sv
// Directed bench for arcabuco_execution: ALU vectors, forwarding muxes,
// multiply/divide results and timing, busy-ignore, reset abort.
module tb_arcabuco_execution;

  logic        clock = 1'b0;
  logic        rst;
  logic [4:0]  alu_selector;
  logic [2:0]  muldiv_selector;
  logic        muldiv_en;
  logic [1:0]  mux1_select, mux2_select;
  logic        mux3_select;
  logic [31:0] rs1, rs2, imm, fw1, fw2;
  logic [31:0] alu_result, store_data, muldiv_result;
  logic        comp_res, arith_ovf, muldiv_busy, muldiv_done;

  int checks = 0;
  int failures = 0;

  arcabuco_execution dut (
    .clock(clock), .rst(rst), .alu_selector(alu_selector),
    .muldiv_selector(muldiv_selector), .muldiv_en(muldiv_en),
    .mux1_select(mux1_select), .mux2_select(mux2_select), .mux3_select(mux3_select),
    .rs1(rs1), .rs2(rs2), .imm(imm), .fw1(fw1), .fw2(fw2),
    .alu_result(alu_result), .comp_res(comp_res), .arith_ovf(arith_ovf),
    .store_data(store_data), .muldiv_result(muldiv_result),
    .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done)
  );

  always #5 clock = ~clock;

  // ALU vectors: op, A (rs1), B (imm), expected result, comp_res, arith_ovf
  localparam int NA = 21;
  localparam logic [4:0]  VA_OP [NA] = '{5'd0, 5'd1, 5'd1, 5'd2, 5'd6, 5'd7, 5'd3, 5'd4, 5'd5, 5'd8,
                                         5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd20, 5'd0, 5'd7};
  localparam logic [31:0] VA_A [NA] = '{32'h7FFFFFFF, 32'h80000000, 32'd5, 32'd1, 32'h80000000, 32'h80000000,
                                        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                        32'd5, 32'd5, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE,
                                        32'd0, 32'd7, 32'hFFFFFFFF, 32'h7FFFFFF0};
  localparam logic [31:0] VA_B [NA] = '{32'd1, 32'd1, 32'd3, 32'h21, 32'd4, 32'd4, 32'd1, 32'd1,
                                        32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'd5, 32'd5, 32'd1, 32'd1,
                                        32'd1, 32'd1, 32'h12345678, 32'd7, 32'd1, 32'h24};
  localparam logic [31:0] VA_R [NA] = '{32'h80000000, 32'h7FFFFFFF, 32'd2, 32'd2, 32'h08000000, 32'hF8000000,
                                        32'd1, 32'd0, 32'h0FF00FF0, 32'hFFF0FFF0, 32'hF000F000, 32'd1, 32'd0,
                                        32'd1, 32'd0, 32'd0, 32'd1, 32'h12345678, 32'd0, 32'd0, 32'h07FFFFFF};
  localparam logic        VA_C [NA] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0};
  localparam logic        VA_V [NA] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  // Mul vectors: selector, A, B, expected result
  localparam int NM = 5;
  localparam logic [2:0]  VM_OP [NM] = '{3'd3, 3'd1, 3'd0, 3'd2, 3'd0};
  localparam logic [31:0] VM_A [NM]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd12345};
  localparam logic [31:0] VM_B [NM]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1000};
  localparam logic [31:0] VM_R [NM]  = '{32'hFFFFFFFE, 32'd0, 32'd1, 32'hFFFFFFFF, 32'd12345000};

  // Div vectors: selector, A, B, expected result
  localparam int ND = 8;
  localparam logic [2:0]  VD_OP [ND] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd5, 3'd7};
  localparam logic [31:0] VD_A [ND]  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'h80000000,
                                         32'h80000000, 32'd100, 32'd100};
  localparam logic [31:0] VD_B [ND]  = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7};
  localparam logic [31:0] VD_R [ND]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'h80000000,
                                         32'd0, 32'd14, 32'd2};

  task automatic set_ab(input logic [31:0] a, input logic [31:0] b);
    mux1_select = 2'd0;
    mux3_select = 1'b1;
    rs1 = a;
    imm = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    muldiv_en = 1'b1;
    muldiv_selector = 3'd0;
    alu_selector = 5'd0;
    set_ab(32'd2, 32'd3);
    repeat (3) @(negedge clock);
    checks++;
    if ({muldiv_busy, muldiv_done, muldiv_result} !== {1'b0, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL reset_state busy=%0b done=%0b result=%h expected 0 0 0", muldiv_busy, muldiv_done, muldiv_result);
    end
    checks++;
    if (alu_result !== 32'd5) begin
      failures++;
      $display("FAIL alu_during_reset got=%h expected=%h", alu_result, 32'd5);
    end
    muldiv_en = 1'b0;
    rst = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_alu();
    for (int i = 0; i < NA; i++) begin
      alu_selector = VA_OP[i];
      set_ab(VA_A[i], VA_B[i]);
      #1;
      checks++;
      if ({alu_result, comp_res, arith_ovf} !== {VA_R[i], VA_C[i], VA_V[i]}) begin
        failures++;
        $display("FAIL alu_vec%0d got res=%h cmp=%0b ovf=%0b expected res=%h cmp=%0b ovf=%0b",
                 i, alu_result, comp_res, arith_ovf, VA_R[i], VA_C[i], VA_V[i]);
      end
    end
  endtask

  task automatic test_forwarding();
    rs1 = 32'h11; rs2 = 32'h22; imm = 32'd1; fw1 = 32'd1; fw2 = 32'h44;
    mux1_select = 2'd1; mux2_select = 2'd1; mux3_select = 1'b1;
    alu_selector = 5'd0;
    #1;
    checks++;
    if ({alu_result, arith_ovf, comp_res, store_data} !== {32'd2, 1'b0, 1'b0, 32'd1}) begin
      failures++;
      $display("FAIL fwd_add got res=%h ovf=%0b cmp=%0b sd=%h expected 2 0 0 1",
               alu_result, arith_ovf, comp_res, store_data);
    end
    mux1_select = 2'd2; mux2_select = 2'd0; mux3_select = 1'b0;
    #1;
    checks++;
    if ({alu_result, store_data} !== {32'h66, 32'h22}) begin
      failures++;
      $display("FAIL fwd_fw2_rs2 got res=%h sd=%h expected 66 22", alu_result, store_data);
    end
    mux1_select = 2'd3; mux2_select = 2'd2; mux3_select = 1'b1; imm = 32'h100;
    #1;
    checks++;
    if ({alu_result, store_data} !== {32'h100, 32'h44}) begin
      failures++;
      $display("FAIL fwd_zero_imm got res=%h sd=%h expected 100 44", alu_result, store_data);
    end
    mux2_select = 2'd3; mux3_select = 1'b0; mux1_select = 2'd0;
    #1;
    checks++;
    if ({alu_result, store_data} !== {32'h11, 32'd0}) begin
      failures++;
      $display("FAIL fwd_b_zero got res=%h sd=%h expected 11 0", alu_result, store_data);
    end
  endtask

  task automatic test_mul();
    for (int i = 0; i < NM; i++) begin
      @(negedge clock);
      muldiv_selector = VM_OP[i];
      set_ab(VM_A[i], VM_B[i]);
      muldiv_en = 1'b1;
      @(negedge clock);
      muldiv_en = 1'b0;
      checks++;
      if ({muldiv_done, muldiv_busy, muldiv_result} !== {1'b1, 1'b0, VM_R[i]}) begin
        failures++;
        $display("FAIL mul_vec%0d got done=%0b busy=%0b res=%h expected 1 0 %h",
                 i, muldiv_done, muldiv_busy, muldiv_result, VM_R[i]);
      end
      @(negedge clock);
      checks++;
      if ({muldiv_done, muldiv_result} !== {1'b0, VM_R[i]}) begin
        failures++;
        $display("FAIL mul_pulse%0d got done=%0b res=%h expected 0 %h", i, muldiv_done, muldiv_result, VM_R[i]);
      end
    end
  endtask

  task automatic test_div();
    int bad;
    for (int i = 0; i < ND; i++) begin
      @(negedge clock);
      muldiv_selector = VD_OP[i];
      set_ab(VD_A[i], VD_B[i]);
      muldiv_en = 1'b1;
      @(negedge clock);
      muldiv_en = 1'b0;
      bad = 0;
      for (int c = 1; c <= 32; c++) begin
        if (c > 1) @(negedge clock);
        if (!(muldiv_busy === 1'b1 && muldiv_done === 1'b0)) bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL div_busy%0d cycles_wrong=%0d expected 0", i, bad);
      end
      @(negedge clock);
      checks++;
      if ({muldiv_done, muldiv_busy, muldiv_result} !== {1'b1, 1'b0, VD_R[i]}) begin
        failures++;
        $display("FAIL div_vec%0d got done=%0b busy=%0b res=%h expected 1 0 %h",
                 i, muldiv_done, muldiv_busy, muldiv_result, VD_R[i]);
      end
      @(negedge clock);
      checks++;
      if ({muldiv_done, muldiv_result} !== {1'b0, VD_R[i]}) begin
        failures++;
        $display("FAIL div_hold%0d got done=%0b res=%h expected 0 %h", i, muldiv_done, muldiv_result, VD_R[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    muldiv_selector = 3'd0;
    set_ab(32'd3, 32'd4);
    muldiv_en = 1'b1;
    @(negedge clock);
    muldiv_selector = 3'd3;
    set_ab(32'hFFFFFFFF, 32'hFFFFFFFF);
    checks++;
    if ({muldiv_done, muldiv_result} !== {1'b1, 32'd12}) begin
      failures++;
      $display("FAIL b2b_first got done=%0b res=%h expected 1 0000000c", muldiv_done, muldiv_result);
    end
    @(negedge clock);
    muldiv_selector = 3'd5;
    set_ab(32'd100, 32'd7);
    checks++;
    if ({muldiv_done, muldiv_result} !== {1'b1, 32'hFFFFFFFE}) begin
      failures++;
      $display("FAIL b2b_second got done=%0b res=%h expected 1 fffffffe", muldiv_done, muldiv_result);
    end
    @(negedge clock);
    muldiv_en = 1'b0;
    checks++;
    if ({muldiv_busy, muldiv_done} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_div_start got busy=%0b done=%0b expected 1 0", muldiv_busy, muldiv_done);
    end
    repeat (33) @(negedge clock);
    checks++;
    if (muldiv_result !== 32'd14 || muldiv_busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_div_result got res=%h busy=%0b expected 0000000e 0", muldiv_result, muldiv_busy);
    end
  endtask

  task automatic test_busy_ignore();
    int done_cycle;
    @(negedge clock);
    muldiv_selector = 3'd4;
    set_ab(32'hFFFFFFF9, 32'd2);
    muldiv_en = 1'b1;
    @(negedge clock);
    muldiv_en = 1'b0;
    done_cycle = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clock);
      if (c == 5) begin
        muldiv_selector = 3'd0;
        set_ab(32'd3, 32'd4);
        muldiv_en = 1'b1;
      end else begin
        muldiv_en = 1'b0;
      end
      if (muldiv_done === 1'b1 && done_cycle < 0) done_cycle = c;
    end
    checks++;
    if (done_cycle != 33) begin
      failures++;
      $display("FAIL busy_ignore_done_cycle got=%0d expected=33", done_cycle);
    end
    checks++;
    if (muldiv_result !== 32'hFFFFFFFD) begin
      failures++;
      $display("FAIL busy_ignore_result got=%h expected=fffffffd", muldiv_result);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    @(negedge clock);
    muldiv_selector = 3'd4;
    set_ab(32'hFFFFFFF9, 32'd2);
    muldiv_en = 1'b1;
    @(negedge clock);
    muldiv_en = 1'b0;
    repeat (9) @(negedge clock);
    rst = 1'b1;
    muldiv_en = 1'b1;
    @(negedge clock);
    checks++;
    if ({muldiv_busy, muldiv_done, muldiv_result} !== {1'b0, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL reset_abort got busy=%0b done=%0b res=%h expected 0 0 0", muldiv_busy, muldiv_done, muldiv_result);
    end
    muldiv_en = 1'b0;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (muldiv_done !== 1'b0 || muldiv_busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_abort_quiet got activity_cycles=%0d expected 0", seen);
    end
  endtask

  initial begin
    muldiv_en = 1'b0;
    mux2_select = 2'd0;
    rs2 = 32'd0; fw1 = 32'd0; fw2 = 32'd0;
    test_reset();
    test_alu();
    test_forwarding();
    test_mul();
    test_div();
    test_back_to_back();
    test_busy_ignore();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
